fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_pc_counter.sv | 25 ++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared widths, phase encoding and opcode constants for the fetch path.
package fetch_unit_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int OPC_W  = 3;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } phase_e;

  // Opcodes decoded by the sequence controller from IR[7:5].
  localparam logic [OPC_W-1:0] OP_HLT = 3'd0;
  localparam logic [OPC_W-1:0] OP_SKZ = 3'd1;
  localparam logic [OPC_W-1:0] OP_ADD = 3'd2;
  localparam logic [OPC_W-1:0] OP_AND = 3'd3;
  localparam logic [OPC_W-1:0] OP_XOR = 3'd4;
  localparam logic [OPC_W-1:0] OP_LDA = 3'd5;
  localparam logic [OPC_W-1:0] OP_STO = 3'd6;
  localparam logic [OPC_W-1:0] OP_JMP = 3'd7;
endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: load beats increment, both gated by an enable.
module pc_counter
  import fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_din,
  output logic [ADDR_W-1:0] o_pc
);
  logic [ADDR_W-1:0] r_pc;

  // PC register; increment wraps naturally at the address width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_pc <= '0;
    else if (i_en) begin
      if (i_load)       r_pc <= i_din;
      else if (i_inc)   r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;
endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: IR, FETCH/EXEC phase FSM, sticky halt and protocol-error flags.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              memrd,
  input  logic              loadir,
  input  logic              incpc,
  input  logic              loadpc,
  input  logic              halt,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] operand,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              proto_err
);
  phase_e            r_state;
  phase_e            w_state_nxt;
  logic [DATA_W-1:0] r_ir;
  logic              r_halted;
  logic              r_err;
  logic              w_act;      // no halt pending or latched: strobes take effect
  logic              w_ir_ld;
  logic              w_err_set;
  logic [ADDR_W-1:0] w_pc;

  // Phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_state_nxt;
  end

  // Next phase and strobe qualification; an IR load always ends in EXEC,
  // otherwise any PC update closes the instruction.
  always_comb begin
    w_state_nxt = r_state;
    w_act       = !r_halted && !halt;
    w_ir_ld     = 1'b0;
    w_err_set   = 1'b0;
    if (w_act) begin
      w_ir_ld   = loadir && memrd;
      w_err_set = loadir && (!memrd || r_state == EXEC);
      if (w_ir_ld)              w_state_nxt = EXEC;
      else if (incpc || loadpc) w_state_nxt = FETCH;
    end
  end

  // IR capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_ir <= '0;
    else if (w_ir_ld) r_ir <= mem_rdata;
  end

  // Sticky flags: halt latches until reset, and freezes the error flag too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (!r_halted && halt) r_halted <= 1'b1;
      if (w_err_set)         r_err    <= 1'b1;
    end
  end

  pc_counter u_pc (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_act),
    .i_load (loadpc),
    .i_inc  (incpc),
    .i_din  (r_ir[ADDR_W-1:0]),
    .o_pc   (w_pc)
  );

  assign opcode    = r_ir[DATA_W-1 -: OPC_W];
  assign operand   = r_ir[ADDR_W-1:0];
  assign pc        = w_pc;
  assign halted    = r_halted;
  assign proto_err = r_err;
  assign mem_addr  = (r_state == FETCH) ? w_pc : r_ir[ADDR_W-1:0];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus random bench for fetch_unit against a behavioural model.
module tb_fetch_unit;
  logic       clk = 1'b0;
  logic       rst, memrd, loadir, incpc, loadpc, halt;
  logic [7:0] mem_rdata;
  logic [4:0] mem_addr, operand, pc;
  logic [2:0] opcode;
  logic       halted, proto_err;

  fetch_unit dut (
    .clk(clk), .rst(rst), .memrd(memrd), .loadir(loadir), .incpc(incpc),
    .loadpc(loadpc), .halt(halt), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .opcode(opcode), .operand(operand), .pc(pc), .halted(halted),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Reference state
  int unsigned m_pc;
  logic [7:0]  m_ir;
  bit          m_exec, m_halted, m_err;
  int          n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},       8'(pc),        8'(m_pc));
    chk({tag, ".opcode"},   8'(opcode),    8'(m_ir / 32));
    chk({tag, ".operand"},  8'(operand),   8'(m_ir % 32));
    chk({tag, ".mem_addr"}, 8'(mem_addr),  m_exec ? 8'(m_ir % 32) : 8'(m_pc));
    chk({tag, ".halted"},   8'(halted),    8'(m_halted));
    chk({tag, ".err"},      8'(proto_err), 8'(m_err));
  endtask

  function automatic void mdl_reset();
    m_pc = 0; m_ir = 8'h00; m_exec = 0; m_halted = 0; m_err = 0;
  endfunction

  // One clock edge of the instruction-level behaviour.
  function automatic void mdl_edge(bit rd, bit lir, bit inc, bit lpc, bit hlt, logic [7:0] d);
    int unsigned nxt_pc;
    if (m_halted) return;
    if (hlt) begin m_halted = 1; return; end
    nxt_pc = lpc ? (m_ir % 32) : inc ? (m_pc + 1) % 32 : m_pc;
    if (lir && (!rd || m_exec)) m_err = 1;
    if (lir && rd)        begin m_ir = d; m_exec = 1; end
    else if (inc || lpc)  m_exec = 0;
    m_pc = nxt_pc;
  endfunction

  // Drive strobes for one edge, advance model, check 1 ns after the edge.
  task automatic step(input string tag, input bit rd, input bit lir, input bit inc,
                      input bit lpc, input bit hlt, input logic [7:0] d);
    memrd = rd; loadir = lir; incpc = inc; loadpc = lpc; halt = hlt; mem_rdata = d;
    @(posedge clk);
    mdl_edge(rd, lir, inc, lpc, hlt, d);
    #1;
    memrd = 0; loadir = 0; incpc = 0; loadpc = 0; halt = 0;
    check_all(tag);
  endtask

  // Reset pulse between edges; outputs must clear with no clock.
  task automatic pulse_rst(input string tag);
    #1 rst = 1'b1;
    #1 mdl_reset();
    check_all(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; memrd = 0; loadir = 0; incpc = 0; loadpc = 0; halt = 0; mem_rdata = 8'h00;
    mdl_reset();
    #2 check_all("reset");
    rst = 1'b0;

    // Basic fetch
    step("fetchA7", 1, 1, 0, 0, 0, 8'hA7);
    chk("fetchA7.opc_lit", 8'(opcode), 8'h5);
    chk("fetchA7.adr_lit", 8'(mem_addr), 8'd7);

    // pc=3 in EXEC then increment
    pulse_rst("rst1");
    repeat (3) step("inc", 0, 0, 1, 0, 0, 8'h00);
    step("ld", 1, 1, 0, 0, 0, 8'hA7);
    step("inc3", 0, 0, 1, 0, 0, 8'h00);
    chk("inc3.pc_lit", 8'(pc), 8'd4);
    chk("inc3.adr_lit", 8'(mem_addr), 8'd4);

    // wrap 31 -> 0
    step("ld1F", 1, 1, 0, 0, 0, 8'h1F);
    step("lpc31", 0, 0, 0, 1, 0, 8'h00);
    step("ld1F_b", 1, 1, 0, 0, 0, 8'h1F);
    step("wrap", 0, 0, 1, 0, 0, 8'h00);
    chk("wrap.pc_lit", 8'(pc), 8'd0);

    // loadpc beats incpc
    step("ld3C", 1, 1, 0, 0, 0, 8'h3C);
    step("both", 0, 0, 1, 1, 0, 8'h00);
    chk("both.pc_lit", 8'(pc), 8'd28);

    // loadir without memrd, error sticks; also loadir in EXEC
    step("noRd", 0, 1, 0, 0, 0, 8'hFF);
    chk("noRd.err_lit", 8'(proto_err), 8'd1);
    step("legal1", 1, 1, 0, 0, 0, 8'h42);
    step("legal2", 0, 0, 1, 0, 0, 8'h00);
    pulse_rst("rst2");
    step("ldE", 1, 1, 0, 0, 0, 8'h21);
    step("reldE", 1, 1, 0, 0, 0, 8'h63);

    // halt with incpc at pc=5, then ignore everything
    pulse_rst("rst3");
    repeat (5) step("inc", 0, 0, 1, 0, 0, 8'h00);
    step("halt", 0, 0, 1, 0, 1, 8'h00);
    chk("halt.pc_lit", 8'(pc), 8'd5);
    step("hold1", 1, 1, 1, 0, 0, 8'hE9);
    step("hold2", 0, 1, 0, 1, 1, 8'h12);
    pulse_rst("rst_halt");

    // reset mid-EXEC, next fetch from address 0
    step("ldX", 1, 1, 0, 0, 0, 8'hD5);
    pulse_rst("rst_exec");
    step("refetch", 1, 1, 0, 0, 0, 8'h8B);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      int r;
      d = 8'($urandom);
      r = $urandom_range(0, 99);
      if (r < 2) pulse_rst("rnd_rst");
      else step("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                $urandom_range(0, 49) == 0, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
